// File: rtl/sprite_blitter.sv
// Sprite draw engine: walks an SPR_W x SPR_H ROM one pixel per clock and emits framebuffer plots.
// Latency: SPR_W*SPR_H + ROM_LAT + 1 clocks from accepted start to draw_done; no backpressure, start ignored while busy.
module sprite_blitter #(
  parameter int             SPR_W    = 32,
  parameter int             SPR_H    = 32,
  parameter int             ADDR_W   = 10,
  parameter int             CW       = 3,
  parameter int             ROM_LAT  = 1,
  parameter int             SCREEN_W = 640,
  parameter int             SCREEN_H = 480,
  parameter int             KEY_EN   = 1,
  parameter logic [CW-1:0]  KEY      = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic              flip_x,
  input  logic              flip_y,
  input  logic [CW-1:0]     sprite_pixel_data,
  output logic [ADDR_W-1:0] address_out,
  output logic              plot_out,
  output logic [9:0]        x_pix,
  output logic [9:0]        y_pix,
  output logic [CW-1:0]     color,
  output logic              busy,
  output logic              draw_done
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col, src_col;
  logic [ROW_W-1:0]  row, src_row;
  logic [2:0]        flush_cnt;
  logic [9:0]        x_lat, y_lat;
  logic              fx_lat, fy_lat;
  logic              accept, abort_eff, col_last, last_pix;
  logic              vld_0, vld_o;
  logic [10:0]       x_0, y_0, x_o, y_o;

  assign accept    = (state == S_IDLE) && start && !abort;
  assign abort_eff = abort && (state != S_IDLE);
  assign col_last  = (col == COL_W'(SPR_W - 1));
  assign last_pix  = col_last && (row == ROW_W'(SPR_H - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last_pix) state_nxt = (ROM_LAT == 0) ? S_DONE : S_FLUSH;
      S_FLUSH: if (flush_cnt == 3'(ROM_LAT - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_eff) state_nxt = S_IDLE;
  end

  always_comb begin
    busy      = 1'b0;
    draw_done = 1'b0;
    case (state)
      S_RUN, S_FLUSH: busy      = 1'b1;
      S_DONE:         draw_done = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
      fx_lat    <= 1'b0;
      fy_lat    <= 1'b0;
    end else begin
      if (accept) begin
        x_lat  <= x_pos;
        y_lat  <= y_pos;
        fx_lat <= flip_x;
        fy_lat <= flip_y;
        col    <= '0;
        row    <= '0;
      end else if (abort_eff) begin
        col <= '0;
        row <= '0;
      end else if (state == S_RUN) begin
        if (col_last) begin
          col <= '0;
          row <= last_pix ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 3'd1 : 3'd0;
    end
  end

  // Flips only remap the ROM address; screen coordinates always walk left-to-right, top-to-bottom.
  assign src_col     = fx_lat ? COL_W'(SPR_W - 1) - col : col;
  assign src_row     = fy_lat ? ROW_W'(SPR_H - 1) - row : row;
  assign address_out = ADDR_W'(src_row) * ADDR_W'(SPR_W) + ADDR_W'(src_col);

  assign vld_0 = (state == S_RUN) && !abort;
  assign x_0   = {1'b0, x_lat} + 11'(col);
  assign y_0   = {1'b0, y_lat} + 11'(row);

  generate
    if (ROM_LAT == 0) begin : g_nolat
      assign vld_o = vld_0;
      assign x_o   = x_0;
      assign y_o   = y_0;
    end else begin : g_lat
      logic [ROM_LAT-1:0] vld_q;
      logic [10:0]        x_q [ROM_LAT];
      logic [10:0]        y_q [ROM_LAT];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= '0;
          for (int i = 0; i < ROM_LAT; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= abort_eff ? 1'b0 : vld_0;
          x_q[0]   <= x_0;
          y_q[0]   <= y_0;
          for (int i = 1; i < ROM_LAT; i++) begin
            vld_q[i] <= abort_eff ? 1'b0 : vld_q[i-1];
            x_q[i]   <= x_q[i-1];
            y_q[i]   <= y_q[i-1];
          end
        end
      end

      assign vld_o = vld_q[ROM_LAT-1];
      assign x_o   = x_q[ROM_LAT-1];
      assign y_o   = y_q[ROM_LAT-1];
    end
  endgenerate

  assign plot_out = vld_o && (x_o < 11'(SCREEN_W)) && (y_o < 11'(SCREEN_H)) &&
                    !((KEY_EN != 0) && (sprite_pixel_data == KEY));
  assign x_pix    = x_o[9:0];
  assign y_pix    = y_o[9:0];
  assign color    = sprite_pixel_data;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two 4x2 instances (A: ROM_LAT=1 no key, B: ROM_LAT=2 key=0) against a per-cycle draw model.
module tb_sprite_blitter;

  localparam int N   = 8;
  localparam int BIG = 32'h3fffffff;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, flip_x, flip_y;
  logic [9:0] x_pos, y_pos;

  logic [2:0] addr_a, data_a, col_a, addr_b, data_b, col_b, b1;
  logic [9:0] xp_a, yp_a, xp_b, yp_b;
  logic       plot_a, busy_a, done_a, plot_b, busy_b, done_b;

  logic [2:0] rom_a [N];
  logic [2:0] rom_b [N];

  always #5 clk = ~clk;

  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ADDR_W(3), .CW(3), .ROM_LAT(1),
                   .SCREEN_W(640), .SCREEN_H(480), .KEY_EN(0), .KEY(3'b000)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .flip_y(flip_y),
    .sprite_pixel_data(data_a), .address_out(addr_a), .plot_out(plot_a),
    .x_pix(xp_a), .y_pix(yp_a), .color(col_a), .busy(busy_a), .draw_done(done_a));

  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ADDR_W(3), .CW(3), .ROM_LAT(2),
                   .SCREEN_W(640), .SCREEN_H(480), .KEY_EN(1), .KEY(3'b000)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .flip_y(flip_y),
    .sprite_pixel_data(data_b), .address_out(addr_b), .plot_out(plot_b),
    .x_pix(xp_b), .y_pix(yp_b), .color(col_b), .busy(busy_b), .draw_done(done_b));

  // Sprite ROMs with 1 and 2 clocks of read latency.
  always @(posedge clk) begin
    data_a <= rom_a[addr_a];
    b1     <= rom_b[addr_b];
    data_b <= b1;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: one record per instance describing the draw in progress.
  bit  m_act [2];
  int  m_s   [2];
  int  m_ab  [2];
  int  m_x   [2];
  int  m_y   [2];
  bit  m_fx  [2];
  bit  m_fy  [2];

  int obs_plot [2];
  int obs_done [2];
  int obs_busy [2];
  int done_at  [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, d, cyc, act, exp);
    end
  endtask

  function automatic int addr_of(input int d, input int k);
    int r, c;
    r = k / 4;
    c = k % 4;
    if (m_fx[d]) c = 3 - c;
    if (m_fy[d]) r = 1 - r;
    return r * 4 + c;
  endfunction

  function automatic int rom_of(input int d, input int a);
    return (d == 0) ? int'(rom_a[a]) : int'(rom_b[a]);
  endfunction

  function automatic bit is_idle(input int d, input int c);
    int e;
    if (!m_act[d]) return 1'b1;
    e = m_s[d] + N + (d + 1) + 1;
    if (m_ab[d] < e) e = m_ab[d];
    return c > e;
  endfunction

  task automatic check_reset(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_addr"}, d, (d == 0) ? addr_a : addr_b, 0);
      chk({nm, "_plot"}, d, (d == 0) ? plot_a : plot_b, 0);
      chk({nm, "_xpix"}, d, (d == 0) ? xp_a : xp_b, 0);
      chk({nm, "_ypix"}, d, (d == 0) ? yp_a : yp_b, 0);
      chk({nm, "_busy"}, d, (d == 0) ? busy_a : busy_b, 0);
      chk({nm, "_done"}, d, (d == 0) ? done_a : done_b, 0);
    end
  endtask

  task automatic check_cycle(input int c);
    for (int d = 0; d < 2; d++) begin
      int  lt, k, j, a, xe, ye, dat;
      bit  be, de, pe;
      logic       op, ob, od;
      logic [2:0] oa, oc;
      logic [9:0] ox, oy;
      lt = d + 1;
      be = 0; de = 0; pe = 0; xe = 0; ye = 0; dat = 0;
      op = (d == 0) ? plot_a : plot_b;
      ob = (d == 0) ? busy_a : busy_b;
      od = (d == 0) ? done_a : done_b;
      oa = (d == 0) ? addr_a : addr_b;
      oc = (d == 0) ? col_a  : col_b;
      ox = (d == 0) ? xp_a   : xp_b;
      oy = (d == 0) ? yp_a   : yp_b;
      if (m_act[d]) begin
        k  = c - m_s[d] - 1;
        j  = k - lt;
        be = (k >= 0) && (k < N + lt) && (c <= m_ab[d]);
        de = (k == N + lt) && (c <= m_ab[d]);
        if (k >= 0 && k < N && c <= m_ab[d]) chk("addr", d, oa, addr_of(d, k));
        if (j >= 0 && j < N && c <= m_ab[d]) begin
          a   = addr_of(d, j);
          dat = rom_of(d, a);
          xe  = m_x[d] + j % 4;
          ye  = m_y[d] + j / 4;
          pe  = (xe < 640) && (ye < 480) && !(d == 1 && dat == 0);
        end
      end
      chk("busy", d, ob, be);
      chk("done", d, od, de);
      chk("plot", d, op, pe);
      if (pe) begin
        chk("x_pix", d, ox, xe % 1024);
        chk("y_pix", d, oy, ye % 1024);
        chk("color", d, oc, dat);
      end
      obs_plot[d] += int'(op);
      obs_done[d] += int'(od);
      obs_busy[d] += int'(ob);
      if (od === 1'b1) done_at[d] = c;
    end
  endtask

  task automatic step(input bit st, input bit ab, input logic [9:0] x, input logic [9:0] y,
                      input bit fx, input bit fy);
    start  = st;
    abort  = ab;
    x_pos  = x;
    y_pos  = y;
    flip_x = fx;
    flip_y = fy;
    for (int d = 0; d < 2; d++) begin
      if (is_idle(d, cyc)) begin
        if (st && !ab) begin
          m_act[d] = 1'b1;
          m_s[d]   = cyc;
          m_ab[d]  = BIG;
          m_x[d]   = int'(x);
          m_y[d]   = int'(y);
          m_fx[d]  = fx;
          m_fy[d]  = fy;
        end
      end else if (ab) begin
        m_ab[d] = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_cycle(cyc);
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      obs_plot[d] = 0;
      obs_done[d] = 0;
      obs_busy[d] = 0;
      done_at[d]  = -1;
    end
  endtask

  typedef struct {
    logic [9:0] x, y;
    bit         fx, fy;
    int         ab_at;
    int         plots_a, plots_b;
    int         done_n;
    int         busy_a, busy_b;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    tbl[0] = '{x:100,  y:50,  fx:0, fy:0, ab_at:0, plots_a:8, plots_b:4, done_n:1, busy_a:9, busy_b:10};
    tbl[1] = '{x:100,  y:50,  fx:1, fy:1, ab_at:0, plots_a:8, plots_b:4, done_n:1, busy_a:9, busy_b:10};
    tbl[2] = '{x:638,  y:50,  fx:0, fy:0, ab_at:0, plots_a:4, plots_b:2, done_n:1, busy_a:9, busy_b:10};
    tbl[3] = '{x:100,  y:479, fx:0, fy:0, ab_at:0, plots_a:4, plots_b:2, done_n:1, busy_a:9, busy_b:10};
    tbl[4] = '{x:638,  y:479, fx:0, fy:0, ab_at:0, plots_a:2, plots_b:1, done_n:1, busy_a:9, busy_b:10};
    tbl[5] = '{x:10,   y:20,  fx:0, fy:0, ab_at:3, plots_a:2, plots_b:0, done_n:0, busy_a:3, busy_b:3};
    tbl[6] = '{x:0,    y:0,   fx:1, fy:0, ab_at:0, plots_a:8, plots_b:4, done_n:1, busy_a:9, busy_b:10};
    tbl[7] = '{x:1022, y:100, fx:0, fy:0, ab_at:0, plots_a:0, plots_b:0, done_n:1, busy_a:9, busy_b:10};

    for (int i = 0; i < N; i++) begin
      rom_a[i] = 3'(i);
      rom_b[i] = (i % 2 == 1) ? 3'd5 : 3'd0;
    end
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      m_ab[d]  = BIG;
    end
    reset_n = 1'b0;
    start = 0; abort = 0; flip_x = 0; flip_y = 0; x_pos = '0; y_pos = '0;
    #2;
    check_reset("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed draws: expected plot/busy/done counts per instance.
    for (int r = 0; r < 8; r++) begin
      int last;
      clear_obs();
      s = cyc;
      step(1, 0, tbl[r].x, tbl[r].y, tbl[r].fx, tbl[r].fy);
      last = (tbl[r].ab_at != 0) ? tbl[r].ab_at : 11;
      for (int i = 1; i <= last; i++)
        step(0, (i == tbl[r].ab_at), tbl[r].x, tbl[r].y, tbl[r].fx, tbl[r].fy);
      chk($sformatf("row%0d_plots", r), 0, obs_plot[0], tbl[r].plots_a);
      chk($sformatf("row%0d_plots", r), 1, obs_plot[1], tbl[r].plots_b);
      chk($sformatf("row%0d_dones", r), 0, obs_done[0], tbl[r].done_n);
      chk($sformatf("row%0d_dones", r), 1, obs_done[1], tbl[r].done_n);
      chk($sformatf("row%0d_busy", r), 0, obs_busy[0], tbl[r].busy_a);
      chk($sformatf("row%0d_busy", r), 1, obs_busy[1], tbl[r].busy_b);
      if (tbl[r].done_n != 0) begin
        chk($sformatf("row%0d_done_lat", r), 0, done_at[0] - s, 10);
        chk($sformatf("row%0d_done_lat", r), 1, done_at[1] - s, 11);
      end
    end

    // Asynchronous reset mid-draw, then start held high for the whole draw.
    step(1, 0, 10'd200, 10'd100, 0, 0);
    step(0, 0, 10'd200, 10'd100, 0, 0);
    step(0, 0, 10'd200, 10'd100, 0, 0);
    step(0, 0, 10'd200, 10'd100, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    for (int d = 0; d < 2; d++) m_act[d] = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    reset_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 11; i++) step(1, 0, 10'd300, 10'd200, 0, 0);
    for (int i = 0; i < 3; i++)  step(0, 0, 10'd300, 10'd200, 0, 0);
    chk("held_start_dones", 0, obs_done[0], 1);
    chk("held_start_dones", 1, obs_done[1], 1);
    chk("held_start_busy", 0, obs_busy[0], 9);
    chk("held_start_busy", 1, obs_busy[1], 10);

    // Randomized traffic with fresh ROM contents.
    for (int i = 0; i < N; i++) begin
      rom_a[i] = 3'($urandom_range(0, 7));
      rom_b[i] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    end
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] rx, ry;
      rx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(630, 1023)) : 10'($urandom_range(0, 639));
      ry = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(470, 1023)) : 10'($urandom_range(0, 479));
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 30) == 0), rx, ry,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 15; i++) step(0, 0, 10'd0, 10'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised sprite-draw engine for the asteroids display path, successor to the fixed 32x32 sprite drawer.
- On a start pulse, walks a rectangular SPR_W x SPR_H sprite ROM one pixel per clock and emits framebuffer write strobes with screen coordinates.
- Extra features: pipelined ROM latency compensation, horizontal/vertical flip, transparent colour key, screen-edge clipping, abort, and a done pulse.
- Sits between the game-object FSM and the VGA framebuffer writer.

Parameters:
SPR_W, 32, sprite width in pixels (>=1)
SPR_H, 32, sprite height in pixels (>=1)
ADDR_W, 10, sprite ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
CW, 3, colour width
ROM_LAT, 1, sprite ROM read latency in clocks (0..4)
SCREEN_W, 640, screen width; columns >= SCREEN_W are clipped
SCREEN_H, 480, screen height; rows >= SCREEN_H are clipped
KEY_EN, 1, 1 = suppress pixels whose colour equals KEY
KEY, 3'b000, transparent colour value

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in S_IDLE
abort  in  1  synchronous cancel of the current draw
x_pos  in  10  sprite top-left x, latched on accepted start
y_pos  in  10  sprite top-left y, latched on accepted start
flip_x  in  1  mirror horizontally, latched on accepted start
flip_y  in  1  mirror vertically, latched on accepted start
sprite_pixel_data  in  CW  ROM data, valid ROM_LAT clocks after address_out
address_out  out  ADDR_W  sprite ROM read address
plot_out  out  1  framebuffer write strobe
x_pix  out  10  screen x for plot_out
y_pix  out  10  screen y for plot_out
color  out  CW  pixel colour, equal to sprite_pixel_data
busy  out  1  high from accepted start until done or abort
draw_done  out  1  one-cycle pulse after the last pixel leaves the pipeline

Behaviour:
- Reset (async, reset_n=0): state S_IDLE. address_out, x_pix, y_pix, plot_out, busy, draw_done, col/row counters and all delay-line valid bits = 0.
- States:
  - S_IDLE: start=1 latches x_pos, y_pos, flip_x, flip_y; clears col=row=0; next state S_RUN; busy=1 from the next cycle.
  - S_RUN: issues one ROM address per clock.
    - col increments each clock; at col=SPR_W-1, col wraps to 0 and row increments.
    - Issuing the pixel (col=SPR_W-1, row=SPR_H-1) moves to S_FLUSH.
  - S_FLUSH: waits ROM_LAT clocks for the delay line to drain, then enters S_DONE. With ROM_LAT=0, S_FLUSH lasts 0 clocks.
  - S_DONE: draw_done=1 for exactly one clock, busy=0, then S_IDLE.
- Address: src_col = flip_x ? SPR_W-1-col : col; src_row = flip_y ? SPR_H-1-row : row; address_out = src_row*SPR_W + src_col. Combinational from the counters, so it is valid in the same cycle the counters hold.
- Pipeline: valid, x = x_lat+col and y = y_lat+row (computed 11 bits wide) pass through a ROM_LAT-deep register delay line.
- plot_out = delayed valid AND x<SCREEN_W AND y<SCREEN_H AND NOT(KEY_EN AND sprite_pixel_data==KEY).
- x_pix and y_pix = delayed coordinates truncated to 10 bits. They are driven even when plot_out=0.
- Clipped and transparent pixels still consume their cycle; counters never skip.
- Total latency from accepted start to draw_done: SPR_W*SPR_H + ROM_LAT + 1 clocks.
- start while busy: ignored, with no queueing.
- start in the same cycle as draw_done: ignored. start is accepted only in S_IDLE.
- abort (any non-IDLE state): next state S_IDLE; all delay-line valid bits cleared so no further plot_out; busy=0 next clock; no draw_done. abort in S_IDLE has no effect. abort wins over start.
- Async reset mid-draw: all outputs go to their reset values immediately; no partial done.

Test Plan:
- SPR_W=4, SPR_H=2, ROM_LAT=1, KEY_EN=0, start with x=100, y=50:
  - 8 plot_out pulses, in order (100,50)..(103,50), (100,51)..(103,51).
  - address_out sequence 0..7.
  - draw_done 10 clocks after start; busy high 9 clocks.
- Same config with flip_x=1, flip_y=1: address_out sequence 7,6,5,4,3,2,1,0 while the coordinate order is unchanged.
- KEY_EN=1, KEY=0, ROM data alternating 0 and 5: only the 4 colour-5 pixels assert plot_out; draw_done timing unchanged.
- x_pos=638, SPR_W=4: columns 640 and 641 are suppressed; 2 of 4 plots per row remain; y_pos=479 with SPR_H=2 suppresses the whole second row.
- Abort on the 3rd RUN cycle, ROM_LAT=2: at most 2 further plot_outs already in flight are killed (zero plots after the abort edge); no draw_done; a new start 1 clock later draws a full sprite.
- reset_n pulsed low mid-draw, plus start held high while busy: outputs zero asynchronously; the start held during busy produces no second draw.
